// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Purpose  : Two-requester APB arbiter/sequencer. Grants the shared
//            downstream APB bus round-robin, replays the granted request as
//            a SETUP/ACCESS sequence and terminates hung slaves with an
//            error response after TIMEOUT_CYCLES ACCESS cycles.
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [1:0]                  req_psel_i,
    input  logic [1:0]                  req_penable_i,
    input  logic [1:0]                  req_pwrite_i,
    input  logic [2*ADDR_WIDTH-1:0]     req_paddr_i,
    input  logic [2*DATA_WIDTH-1:0]     req_pwdata_i,
    input  logic [2*DATA_WIDTH/8-1:0]   req_pstrb_i,
    input  logic [5:0]                  req_pprot_i,
    output logic [1:0]                  req_pready_o,
    output logic [DATA_WIDTH-1:0]       req_prdata_o,
    output logic                        req_pslverr_o,
    output logic                        m_psel_o,
    output logic                        m_penable_o,
    output logic                        m_pwrite_o,
    output logic [ADDR_WIDTH-1:0]       m_paddr_o,
    output logic [DATA_WIDTH-1:0]       m_pwdata_o,
    output logic [DATA_WIDTH/8-1:0]     m_pstrb_o,
    output logic [2:0]                  m_pprot_o,
    input  logic                        m_pready_i,
    input  logic [DATA_WIDTH-1:0]       m_prdata_i,
    input  logic                        m_pslverr_i,
    output logic                        timeout_flag_o,
    input  logic                        timeout_clr_i,
    output logic [7:0]                  timeout_cnt_o
);

    localparam int          STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [15:0] TO_LIMIT   = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q,   state_d;
    logic                    grant_q,   grant_d;
    logic                    rr_ptr_q,  rr_ptr_d;
    logic                    pwrite_q,  pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q,   pstrb_d;
    logic [2:0]              pprot_q,   pprot_d;
    logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic [15:0]             wd_cnt_q,  wd_cnt_d;
    logic                    to_flag_q, to_flag_d;
    logic [7:0]              to_cnt_q,  to_cnt_d;

    // PENABLE from the requesters carries no information the arbiter needs:
    // a request is recognised from PSEL alone while the bus is idle.
    logic unused_penable;
    assign unused_penable = ^req_penable_i;

    // Requester 1 wins when it is the only candidate, or when both request
    // and the round-robin pointer favours it.
    logic gnt_sel;
    assign gnt_sel = req_psel_i[1] & (~req_psel_i[0] | rr_ptr_q);

    // Next-state, request capture, watchdog and timeout bookkeeping.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        wd_cnt_d  = wd_cnt_q;
        to_flag_d = to_flag_q;
        to_cnt_d  = to_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_psel_i != 2'b00) begin
                    grant_d = gnt_sel;
                    state_d = S_SETUP;
                    if (gnt_sel) begin
                        pwrite_d = req_pwrite_i[1];
                        paddr_d  = req_paddr_i[ADDR_WIDTH +: ADDR_WIDTH];
                        pwdata_d = req_pwdata_i[DATA_WIDTH +: DATA_WIDTH];
                        pstrb_d  = req_pstrb_i[STRB_WIDTH +: STRB_WIDTH];
                        pprot_d  = req_pprot_i[3 +: 3];
                    end else begin
                        pwrite_d = req_pwrite_i[0];
                        paddr_d  = req_paddr_i[0 +: ADDR_WIDTH];
                        pwdata_d = req_pwdata_i[0 +: DATA_WIDTH];
                        pstrb_d  = req_pstrb_i[0 +: STRB_WIDTH];
                        pprot_d  = req_pprot_i[0 +: 3];
                    end
                end
            end
            S_SETUP: begin
                // The first ACCESS cycle counts as 1.
                wd_cnt_d = 16'd1;
                state_d  = S_ACCESS;
            end
            S_ACCESS: begin
                if (m_pready_i) begin
                    prdata_d  = pwrite_q ? '0 : m_prdata_i;
                    pslverr_d = m_pslverr_i;
                    state_d   = S_DONE;
                end else if (wd_cnt_q == TO_LIMIT) begin
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    to_flag_d = 1'b1;
                    if (to_cnt_q != 8'hFF) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                    state_d   = S_DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                rr_ptr_d = ~grant_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A clear request beats an expiry landing in the same cycle.
        if (timeout_clr_i) begin
            to_flag_d = 1'b0;
            to_cnt_d  = 8'd0;
        end
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            rr_ptr_q  <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            wd_cnt_q  <= '0;
            to_flag_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            wd_cnt_q  <= wd_cnt_d;
            to_flag_q <= to_flag_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign req_pready_o   = {(state_q == S_DONE) &  grant_q,
                             (state_q == S_DONE) & ~grant_q};
    assign req_prdata_o   = prdata_q;
    assign req_pslverr_o  = pslverr_q;
    assign m_psel_o       = (state_q == S_SETUP) | (state_q == S_ACCESS);
    assign m_penable_o    = (state_q == S_ACCESS);
    assign m_pwrite_o     = pwrite_q;
    assign m_paddr_o      = paddr_q;
    assign m_pwdata_o     = pwdata_q;
    assign m_pstrb_o      = pstrb_q;
    assign m_pprot_o      = pprot_q;
    assign timeout_flag_o = to_flag_q;
    assign timeout_cnt_o  = to_cnt_q;

endmodule
`default_nettype wire
